dm_apb_mem_bridge: RTL

- Parametrised APB4-slave-to-memory-port bridge between the SoC peripheral bus and the debug module's memory interface (dm_mem req/we/addr/be/wdata/rdata).
- Replaces the fixed APB-to-peripheral converter and its one-cycle valid register.
- Adds:
  - configurable APB and memory data widths, with byte-lane steering;
  - a req/gnt handshake towards memory;
  - configurable read latency;
  - PSLVERR for out-of-window and misaligned accesses.

---
 rtl/dm_apb_mem_bridge_pkg.sv | 24 ++
 rtl/dm_lane_steer.sv | 43 ++++
 rtl/dm_apb_mem_bridge.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dm_apb_mem_bridge_pkg.sv
// Shared debug-module constants: default bridge window and width-legality helpers.
package dm_apb_mem_bridge_pkg;

    localparam int unsigned DefaultAddrWidth    = 32;
    localparam int unsigned DefaultDataWidth    = 32;
    localparam int unsigned DefaultMemDataWidth = 64;
    localparam int unsigned DefaultMemAddrWidth = 15;
    localparam logic [63:0] DefaultBaseAddr     = 64'h0;
    localparam int unsigned DefaultWindowSize   = 32'h8000;

    localparam int unsigned MinReadLatency = 1;
    localparam int unsigned MaxReadLatency = 4;

    // True for a non-zero power of two.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // APB side is 32 or 64 bits; the memory port must be a whole number of APB lanes.
    function automatic bit dm_widths_legal(input int unsigned dw, input int unsigned mdw);
        return ((dw == 32) || (dw == 64)) && (mdw >= dw) && ((mdw % dw) == 0);
    endfunction

endpackage

// File: rtl/dm_lane_steer.sv
// Byte-lane steering between a narrow bus and a wide memory word.
module dm_lane_steer #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned MemDataWidth = 64,
    localparam int unsigned Lanes        = MemDataWidth / DataWidth,
    localparam int unsigned LaneWidth    = (Lanes > 1) ? $clog2(Lanes) : 1,
    localparam int unsigned StrbWidth    = DataWidth / 8,
    localparam int unsigned MemStrbWidth = MemDataWidth / 8
) (
    input  logic                    we_i,
    input  logic [LaneWidth-1:0]    wr_lane_i,
    input  logic [DataWidth-1:0]    wdata_i,
    input  logic [StrbWidth-1:0]    strb_i,
    output logic [MemDataWidth-1:0] wdata_o,
    output logic [MemStrbWidth-1:0] be_o,
    input  logic [LaneWidth-1:0]    rd_lane_i,
    input  logic [MemDataWidth-1:0] rdata_i,
    output logic [DataWidth-1:0]    rdata_o
);

    logic [StrbWidth-1:0] lane_strb;

    // Reads enable the whole addressed lane; writes use the bus strobes.
    always_comb begin
        lane_strb = we_i ? strb_i : {StrbWidth{1'b1}};
        wdata_o   = {Lanes{wdata_i}};
    end

    if (Lanes == 1) begin : g_single_lane
        // One lane: straight pass-through in both directions.
        always_comb begin
            be_o    = lane_strb;
            rdata_o = rdata_i;
        end
    end else begin : g_multi_lane
        // Shift strobes into the addressed lane and pick the read slice.
        always_comb begin
            be_o    = MemStrbWidth'(lane_strb) << (StrbWidth * wr_lane_i);
            rdata_o = rdata_i[rd_lane_i*DataWidth +: DataWidth];
        end
    end

endmodule

// File: rtl/dm_apb_mem_bridge.sv
// APB4 slave to debug-module memory port bridge with req/gnt and fixed read latency.
module dm_apb_mem_bridge
    import dm_apb_mem_bridge_pkg::*;
#(
    parameter int unsigned          AddrWidth    = DefaultAddrWidth,
    parameter int unsigned          DataWidth    = DefaultDataWidth,
    parameter int unsigned          MemDataWidth = DefaultMemDataWidth,
    parameter int unsigned          MemAddrWidth = DefaultMemAddrWidth,
    parameter logic [AddrWidth-1:0] BaseAddr     = AddrWidth'(DefaultBaseAddr),
    parameter int unsigned          WindowSize   = DefaultWindowSize,
    parameter int unsigned          ReadLatency  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [AddrWidth-1:0]      paddr_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [DataWidth-1:0]      pwdata_i,
    input  logic [DataWidth/8-1:0]    pstrb_i,
    output logic [DataWidth-1:0]      prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      req_o,
    input  logic                      gnt_i,
    output logic                      we_o,
    output logic [63:0]               addr_o,
    output logic [MemDataWidth/8-1:0] be_o,
    output logic [MemDataWidth-1:0]   wdata_o,
    input  logic [MemDataWidth-1:0]   rdata_i
);

    localparam int unsigned StrbWidth    = DataWidth / 8;
    localparam int unsigned MemStrbWidth = MemDataWidth / 8;
    localparam int unsigned Lanes        = MemDataWidth / DataWidth;
    localparam int unsigned LaneWidth    = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int unsigned OffsWidth    = $clog2(StrbWidth);
    localparam logic [AddrWidth-1:0] WinMask = ~(AddrWidth'(WindowSize - 1));

    // Reject illegal parameter sets at elaboration.
    if (!dm_widths_legal(DataWidth, MemDataWidth) || (ReadLatency < MinReadLatency) ||
        (ReadLatency > MaxReadLatency) || !is_pow2(WindowSize)) begin : g_param_check
        $error("dm_apb_mem_bridge: illegal parameters");
    end

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRwait,
        StRack,
        StWack
    } state_e;

    function automatic logic [LaneWidth-1:0] lane_of(input logic [AddrWidth-1:0] a);
        return (Lanes > 1) ? a[OffsWidth +: LaneWidth] : '0;
    endfunction

    function automatic logic [OffsWidth-1:0] offset_of(input logic [AddrWidth-1:0] a);
        return a[OffsWidth-1:0];
    endfunction

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q;
    logic [LaneWidth-1:0]    lane_q;
    logic [DataWidth-1:0]    prdata_q;
    logic                    access;
    logic                    err;
    logic                    req;
    logic                    pready;
    logic                    pslverr;
    logic                    err_rsp;
    logic                    rd_grant;
    logic                    rd_sample;
    logic [MemDataWidth-1:0] steer_wdata;
    logic [MemStrbWidth-1:0] steer_be;
    logic [DataWidth-1:0]    rd_slice;

    // Access phase qualifier; gated by reset so every output reads 0 while in reset.
    always_comb begin
        access = psel_i & penable_i & rst_ni;
        err    = ((paddr_i & WinMask) != (BaseAddr & WinMask)) || (offset_of(paddr_i) != '0);
    end

    dm_lane_steer #(
        .DataWidth   (DataWidth),
        .MemDataWidth(MemDataWidth)
    ) u_lane_steer (
        .we_i     (pwrite_i),
        .wr_lane_i(lane_of(paddr_i)),
        .wdata_i  (pwdata_i),
        .strb_i   (pstrb_i),
        .wdata_o  (steer_wdata),
        .be_o     (steer_be),
        .rd_lane_i(lane_q),
        .rdata_i  (rdata_i),
        .rdata_o  (rd_slice)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (access && !err) begin
                    if (gnt_i) begin
                        state_d = pwrite_i ? StWack : StRwait;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (gnt_i) begin
                    state_d = pwrite_i ? StWack : StRwait;
                end
            end
            StRwait: begin
                if (cnt_q == 2'd0) begin
                    state_d = StRack;
                end
            end
            StRack:  state_d = StIdle;
            StWack:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs per state; error responses complete with zero wait states.
    always_comb begin
        req     = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        err_rsp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    if (err) begin
                        pready  = 1'b1;
                        pslverr = 1'b1;
                        err_rsp = 1'b1;
                    end else begin
                        req = 1'b1;
                    end
                end
            end
            StReq:   req = 1'b1;
            StRack:  pready = 1'b1;
            StWack:  pready = 1'b1;
            default: ;
        endcase
    end

    // Memory-side fields follow the live APB inputs while a request is up.
    always_comb begin
        req_o     = req;
        pready_o  = pready;
        pslverr_o = pslverr;
        prdata_o  = err_rsp ? '0 : prdata_q;
        we_o      = req & pwrite_i;
        addr_o    = req ? 64'(paddr_i[MemAddrWidth-1:0]) : 64'd0;
        be_o      = req ? steer_be : '0;
        wdata_o   = req ? steer_wdata : '0;
    end

    always_comb begin
        rd_grant  = req & gnt_i & ~pwrite_i;
        rd_sample = (state_q == StRwait) && (cnt_q == 2'd0);
    end

    // Read latency counter, lane capture at grant, and read-data register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= 2'd0;
            lane_q   <= '0;
            prdata_q <= '0;
        end else begin
            if (rd_grant) begin
                cnt_q  <= 2'(ReadLatency - 1);
                lane_q <= lane_of(paddr_i);
            end else if ((state_q == StRwait) && (cnt_q != 2'd0)) begin
                cnt_q <= cnt_q - 2'd1;
            end
            if (rd_sample) begin
                prdata_q <= rd_slice;
            end
        end
    end

endmodule
